// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty,
// optional first-word-fall-through read, synchronous flush and sticky error flags.
module sync_fifo_flags #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int AFULL_THRESH  = 14,
  parameter int AEMPTY_THRESH = 2,
  parameter int FWFT          = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  winc,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rinc,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic                  flush,
  input  logic                  clr_err,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_C  = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   AFULL_C  = AFULL_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   AEMPTY_C = AEMPTY_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  full_int, empty_int;
  logic                  wr_acc, rd_acc;

  // Flags come only from the registered count, so no request input reaches them.
  assign full_int     = (count_q == DEPTH_C);
  assign empty_int    = (count_q == '0);
  assign full         = full_int;
  assign empty        = empty_int;
  assign almost_full  = (count_q >= AFULL_C);
  assign almost_empty = (count_q <= AEMPTY_C);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  always_comb begin
    wr_acc      = winc && !full_int && !flush;
    rd_acc      = rinc && !empty_int && !flush;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (wr_acc) wptr_d = wptr_q + PTR_ONE;
      if (rd_acc) rptr_d = rptr_q + PTR_ONE;
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end

    // Clear first so that an error in the same cycle wins over clr_err.
    if (clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (!flush && winc && full_int)  overflow_d  = 1'b1;
    if (!flush && rinc && empty_int) underflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wptr_q] <= wdata;
  end

  generate
    if (FWFT == 0) begin : g_std_read
      logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

      always_comb begin
        rdata_d = rdata_q;
        if (rd_acc) rdata_d = mem[rptr_q];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata_q <= '0;
        else        rdata_q <= rdata_d;
      end

      assign rdata = rdata_q;
    end else begin : g_fwft_read
      // Head word is visible straight from storage; zero while empty keeps reset clean.
      assign rdata = empty_int ? '0 : mem[rptr_q];
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench: one FIFO built with standard read and one with FWFT,
// both driven by the same stimulus and checked against hand-computed values.
module tb_sync_fifo_flags;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       winc, rinc, flush, clr_err;
  logic [7:0] wdata;

  logic [7:0] r0_rdata, r1_rdata;
  logic       r0_full, r0_empty, r0_afull, r0_aempty, r0_ovf, r0_unf;
  logic       r1_full, r1_empty, r1_afull, r1_aempty, r1_ovf, r1_unf;
  logic [4:0] r0_count, r1_count;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sync_fifo_flags #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AFULL_THRESH(14), .AEMPTY_THRESH(2), .FWFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .winc(winc), .wdata(wdata), .rinc(rinc), .rdata(r0_rdata),
    .flush(flush), .clr_err(clr_err), .full(r0_full), .empty(r0_empty),
    .almost_full(r0_afull), .almost_empty(r0_aempty), .count(r0_count),
    .overflow(r0_ovf), .underflow(r0_unf));

  sync_fifo_flags #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AFULL_THRESH(14), .AEMPTY_THRESH(2), .FWFT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .winc(winc), .wdata(wdata), .rinc(rinc), .rdata(r1_rdata),
    .flush(flush), .clr_err(clr_err), .full(r1_full), .empty(r1_empty),
    .almost_full(r1_afull), .almost_empty(r1_aempty), .count(r1_count),
    .overflow(r1_ovf), .underflow(r1_unf));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; winc = 0; rinc = 0; flush = 0; clr_err = 0; wdata = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    n_cmp++; if (r0_empty !== 1'b1)  begin n_fail++; $display("FAIL reset_empty got %b want 1", r0_empty); end
    n_cmp++; if (r0_aempty !== 1'b1) begin n_fail++; $display("FAIL reset_aempty got %b want 1", r0_aempty); end
    n_cmp++; if (r0_full !== 1'b0)   begin n_fail++; $display("FAIL reset_full got %b want 0", r0_full); end
    n_cmp++; if (r0_afull !== 1'b0)  begin n_fail++; $display("FAIL reset_afull got %b want 0", r0_afull); end
    n_cmp++; if (r0_count !== 5'd0)  begin n_fail++; $display("FAIL reset_count got %0d want 0", r0_count); end
    n_cmp++; if (r0_ovf !== 1'b0)    begin n_fail++; $display("FAIL reset_ovf got %b want 0", r0_ovf); end
    n_cmp++; if (r0_unf !== 1'b0)    begin n_fail++; $display("FAIL reset_unf got %b want 0", r0_unf); end
    n_cmp++; if (r0_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata got %h want 00", r0_rdata); end
    $display("reset: idle state checked");
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 16; i++) begin
      winc = 1; wdata = i[7:0];
      tick();
      n_cmp++; if (r0_count !== i[4:0]) begin n_fail++; $display("FAIL fill_count[%0d] got %0d want %0d", i, r0_count, i); end
      n_cmp++; if (r0_aempty !== (i <= 2)) begin n_fail++; $display("FAIL fill_aempty[%0d] got %b want %b", i, r0_aempty, (i <= 2)); end
      n_cmp++; if (r0_afull !== (i >= 14)) begin n_fail++; $display("FAIL fill_afull[%0d] got %b want %b", i, r0_afull, (i >= 14)); end
      n_cmp++; if (r0_full !== (i == 16)) begin n_fail++; $display("FAIL fill_full[%0d] got %b want %b", i, r0_full, (i == 16)); end
      $display("write %h count=%0d", wdata, r0_count);
    end
    wdata = 8'h11;
    tick();
    winc = 0;
    n_cmp++; if (r0_ovf !== 1'b1)     begin n_fail++; $display("FAIL fill_ovf got %b want 1", r0_ovf); end
    n_cmp++; if (r0_count !== 5'd16)  begin n_fail++; $display("FAIL fill_ovf_count got %0d want 16", r0_count); end
    n_cmp++; if (r1_ovf !== 1'b1)     begin n_fail++; $display("FAIL fill_ovf_fwft got %b want 1", r1_ovf); end
  endtask

  task automatic test_read();
    rinc = 1;
    for (int i = 1; i <= 16; i++) begin
      n_cmp++; if (r1_rdata !== i[7:0]) begin n_fail++; $display("FAIL fwft_head[%0d] got %h want %h", i, r1_rdata, i[7:0]); end
      tick();
      n_cmp++; if (r0_rdata !== i[7:0]) begin n_fail++; $display("FAIL read_data[%0d] got %h want %h", i, r0_rdata, i[7:0]); end
      n_cmp++; if (r0_count !== 5'(16 - i)) begin n_fail++; $display("FAIL read_count[%0d] got %0d want %0d", i, r0_count, 16 - i); end
      n_cmp++; if (r0_empty !== (i == 16)) begin n_fail++; $display("FAIL read_empty[%0d] got %b want %b", i, r0_empty, (i == 16)); end
      $display("read %h count=%0d", r0_rdata, r0_count);
    end
    tick();
    rinc = 0;
    n_cmp++; if (r0_unf !== 1'b1)    begin n_fail++; $display("FAIL read_unf got %b want 1", r0_unf); end
    n_cmp++; if (r0_rdata !== 8'h10) begin n_fail++; $display("FAIL read_hold got %h want 10", r0_rdata); end
    n_cmp++; if (r0_count !== 5'd0)  begin n_fail++; $display("FAIL read_unf_count got %0d want 0", r0_count); end
    clr_err = 1;
    tick();
    clr_err = 0;
    n_cmp++; if (r0_ovf !== 1'b0) begin n_fail++; $display("FAIL clr_ovf got %b want 0", r0_ovf); end
    n_cmp++; if (r0_unf !== 1'b0) begin n_fail++; $display("FAIL clr_unf got %b want 0", r0_unf); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 5; k++) begin
      winc = 1; wdata = 8'hA0 + k[7:0];
      tick();
    end
    rinc = 1;
    for (int k = 0; k < 40; k++) begin
      wdata = 8'hA5 + k[7:0];
      n_cmp++; if (r1_rdata !== 8'hA0 + k[7:0]) begin n_fail++; $display("FAIL b2b_fwft[%0d] got %h want %h", k, r1_rdata, 8'hA0 + k[7:0]); end
      tick();
      n_cmp++; if (r1_count !== 5'd5) begin n_fail++; $display("FAIL b2b_count[%0d] got %0d want 5", k, r1_count); end
      n_cmp++; if (r0_rdata !== 8'hA0 + k[7:0]) begin n_fail++; $display("FAIL b2b_std[%0d] got %h want %h", k, r0_rdata, 8'hA0 + k[7:0]); end
      $display("stream in %h out %h count=%0d", wdata, r0_rdata, r1_count);
    end
    winc = 0;
    for (int j = 0; j < 5; j++) begin
      n_cmp++; if (r1_rdata !== 8'hC8 + j[7:0]) begin n_fail++; $display("FAIL drain_fwft[%0d] got %h want %h", j, r1_rdata, 8'hC8 + j[7:0]); end
      tick();
      n_cmp++; if (r0_rdata !== 8'hC8 + j[7:0]) begin n_fail++; $display("FAIL drain_std[%0d] got %h want %h", j, r0_rdata, 8'hC8 + j[7:0]); end
    end
    rinc = 0;
    n_cmp++; if (r0_empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty got %b want 1", r0_empty); end
    n_cmp++; if (r0_unf !== 1'b0)   begin n_fail++; $display("FAIL drain_unf got %b want 0", r0_unf); end
  endtask

  task automatic test_full_both();
    winc = 1;
    for (int i = 0; i < 16; i++) begin
      wdata = 8'h30 + i[7:0];
      tick();
    end
    rinc = 1; wdata = 8'hFF;
    tick();
    winc = 0; rinc = 0;
    n_cmp++; if (r0_count !== 5'd15) begin n_fail++; $display("FAIL fullrw_count got %0d want 15", r0_count); end
    n_cmp++; if (r0_ovf !== 1'b1)    begin n_fail++; $display("FAIL fullrw_ovf got %b want 1", r0_ovf); end
    n_cmp++; if (r0_rdata !== 8'h30) begin n_fail++; $display("FAIL fullrw_rdata got %h want 30", r0_rdata); end
    n_cmp++; if (r0_unf !== 1'b0)    begin n_fail++; $display("FAIL fullrw_unf got %b want 0", r0_unf); end
    clr_err = 1;
    tick();
    clr_err = 0;
    n_cmp++; if (r0_ovf !== 1'b0) begin n_fail++; $display("FAIL clr_alone got %b want 0", r0_ovf); end
    winc = 1; wdata = 8'h77;
    tick();
    n_cmp++; if (r0_full !== 1'b1) begin n_fail++; $display("FAIL refill_full got %b want 1", r0_full); end
    clr_err = 1;
    tick();
    winc = 0; clr_err = 0;
    n_cmp++; if (r0_ovf !== 1'b1)   begin n_fail++; $display("FAIL clr_vs_set got %b want 1", r0_ovf); end
    n_cmp++; if (r0_count !== 5'd16) begin n_fail++; $display("FAIL clr_vs_set_count got %0d want 16", r0_count); end
    clr_err = 1;
    tick();
    clr_err = 0;
  endtask

  task automatic test_flush();
    flush = 1;
    tick();
    flush = 0;
    n_cmp++; if (r0_count !== 5'd0) begin n_fail++; $display("FAIL flush_full_count got %0d want 0", r0_count); end
    winc = 1;
    for (int i = 0; i < 9; i++) begin
      wdata = 8'h90 + i[7:0];
      tick();
    end
    n_cmp++; if (r0_count !== 5'd9) begin n_fail++; $display("FAIL preflush_count got %0d want 9", r0_count); end
    flush = 1;
    tick();
    flush = 0; winc = 0;
    n_cmp++; if (r0_count !== 5'd0)  begin n_fail++; $display("FAIL flush_count got %0d want 0", r0_count); end
    n_cmp++; if (r0_empty !== 1'b1)  begin n_fail++; $display("FAIL flush_empty got %b want 1", r0_empty); end
    n_cmp++; if (r0_aempty !== 1'b1) begin n_fail++; $display("FAIL flush_aempty got %b want 1", r0_aempty); end
    n_cmp++; if (r0_ovf !== 1'b0)    begin n_fail++; $display("FAIL flush_ovf got %b want 0", r0_ovf); end
    n_cmp++; if (r0_unf !== 1'b0)    begin n_fail++; $display("FAIL flush_unf got %b want 0", r0_unf); end
    n_cmp++; if (r0_rdata !== 8'h30) begin n_fail++; $display("FAIL flush_rdata got %h want 30", r0_rdata); end
    winc = 1; rinc = 1; wdata = 8'h55;
    tick();
    winc = 0; rinc = 0;
    n_cmp++; if (r0_count !== 5'd1)  begin n_fail++; $display("FAIL emptyrw_count got %0d want 1", r0_count); end
    n_cmp++; if (r0_unf !== 1'b1)    begin n_fail++; $display("FAIL emptyrw_unf got %b want 1", r0_unf); end
    n_cmp++; if (r1_rdata !== 8'h55) begin n_fail++; $display("FAIL emptyrw_fwft got %h want 55", r1_rdata); end
    clr_err = 1;
    tick();
    clr_err = 0;
  endtask

  task automatic test_async_reset();
    winc = 1;
    for (int i = 0; i < 3; i++) begin
      wdata = 8'hE0 + i[7:0];
      tick();
    end
    winc = 0;
    n_cmp++; if (r0_count !== 5'd4) begin n_fail++; $display("FAIL prereset_count got %0d want 4", r0_count); end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (r0_count !== 5'd0)  begin n_fail++; $display("FAIL arst_count got %0d want 0", r0_count); end
    n_cmp++; if (r0_empty !== 1'b1)  begin n_fail++; $display("FAIL arst_empty got %b want 1", r0_empty); end
    n_cmp++; if (r0_rdata !== 8'h00) begin n_fail++; $display("FAIL arst_rdata got %h want 00", r0_rdata); end
    n_cmp++; if (r1_count !== 5'd0)  begin n_fail++; $display("FAIL arst_count_fwft got %0d want 0", r1_count); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_read();
    test_back_to_back();
    test_full_both();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
